// File: rtl/pp_selftest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pp_selftest_pkg
// Description : Shared types, default widths and helpers for the register-file
//               scan-and-check self-test logic beside the pipelined processor.
// Revision    : 1.0 - initial release
// ============================================================================
package pp_selftest_pkg;

    // Widths shared with the processor's debug read port
    localparam int REG_ADDR_BITS  = 3;
    localparam int DATA_WIDTH     = 16;
    localparam int MAX_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HALT = 2'd1,
        SCAN      = 2'd2,
        DONE      = 2'd3
    } scan_state_t;

    // Callers zero-extend their operands to MAX_DATA_WIDTH
    function automatic logic maskedMismatch(
        input logic [MAX_DATA_WIDTH-1:0] observed,
        input logic [MAX_DATA_WIDTH-1:0] expected,
        input logic [MAX_DATA_WIDTH-1:0] mask
    );
        return |((observed ^ expected) & mask);
    endfunction

    function automatic int cntWidth(input int maxValue);
        return (maxValue < 1) ? 1 : $clog2(maxValue + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/settle_counter.sv
`default_nettype none
// ============================================================================
// Module      : settle_counter
// Description : Loadable down-counter; o_zero marks the cycle the count is
//               exhausted. Holds at zero until reloaded.
// Revision    : 1.0 - initial release
// ============================================================================
module settle_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_en,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/reg_scan_checker.sv
`default_nettype none
// ============================================================================
// Module      : reg_scan_checker
// Description : After processor halt, steps the debug read index over every
//               register and checks each value against a masked expectation.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scan_checker
    import pp_selftest_pkg::*;
#(
    parameter int RegAddrBits  = REG_ADDR_BITS,
    parameter int DataWidth    = DATA_WIDTH,
    parameter int TotalReg     = 8,
    parameter int SettleCycles = 1,
    parameter int HaltTimeout  = 256
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   start,
    input  logic                   halted,
    output logic [RegAddrBits-1:0] inr,
    input  logic [DataWidth-1:0]   out_value,
    input  logic [DataWidth-1:0]   exp_data,
    input  logic [DataWidth-1:0]   exp_mask,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [RegAddrBits:0]   err_count,
    output logic [RegAddrBits-1:0] first_err_reg,
    output logic [DataWidth-1:0]   first_err_value
);

    localparam int c_SETTLE_W = cntWidth(SettleCycles);
    localparam int c_HALT_W   = cntWidth(HaltTimeout - 1);
    localparam logic [RegAddrBits-1:0] c_LAST_IDX    = RegAddrBits'(TotalReg - 1);
    localparam logic [c_SETTLE_W-1:0]  c_SETTLE_LOAD = c_SETTLE_W'(SettleCycles);
    localparam logic [c_HALT_W-1:0]    c_HALT_LOAD   = c_HALT_W'(HaltTimeout - 1);

    scan_state_t              r_state;
    logic [RegAddrBits-1:0]   r_idx;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_pass;
    logic                     r_timeout;
    logic [RegAddrBits:0]     r_errCount;
    logic [RegAddrBits-1:0]   r_firstErrReg;
    logic [DataWidth-1:0]     r_firstErrValue;

    logic                     w_settleZero;
    logic                     w_waitZero;
    logic                     w_startReq;
    logic                     w_enterScan;
    logic                     w_compare;
    logic                     w_advance;
    logic                     w_mismatch;
    logic [RegAddrBits:0]     w_errNext;

    assign w_startReq  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_enterScan = (r_state == WAIT_HALT) && halted;
    assign w_compare   = (r_state == SCAN) && w_settleZero;
    assign w_advance   = w_compare && (r_idx != c_LAST_IDX);
    assign w_mismatch  = maskedMismatch(MAX_DATA_WIDTH'(out_value),
                                        MAX_DATA_WIDTH'(exp_data),
                                        MAX_DATA_WIDTH'(exp_mask));
    // Count saturates at all-ones so it can never wrap back to "no errors"
    assign w_errNext   = (w_mismatch && (r_errCount != '1)) ? r_errCount + 1'b1
                                                            : r_errCount;

    settle_counter #(
        .WIDTH (c_SETTLE_W)
    ) u_settle (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_load      (w_enterScan || w_advance),
        .i_loadValue (c_SETTLE_LOAD),
        .i_en        (r_state == SCAN),
        .o_zero      (w_settleZero)
    );

    settle_counter #(
        .WIDTH (c_HALT_W)
    ) u_haltWait (
        .clk         (CLK),
        .rst_n       (RST_N),
        .i_load      (w_startReq),
        .i_loadValue (c_HALT_LOAD),
        .i_en        (r_state == WAIT_HALT),
        .o_zero      (w_waitZero)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_timeout       <= 1'b0;
            r_errCount      <= '0;
            r_firstErrReg   <= '0;
            r_firstErrValue <= '0;
        end else begin
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state         <= WAIT_HALT;
                        r_idx           <= '0;
                        r_busy          <= 1'b1;
                        r_done          <= 1'b0;
                        r_pass          <= 1'b0;
                        r_timeout       <= 1'b0;
                        r_errCount      <= '0;
                        r_firstErrReg   <= '0;
                        r_firstErrValue <= '0;
                    end
                end
                WAIT_HALT: begin
                    if (halted) begin
                        r_state <= SCAN;
                        r_idx   <= '0;
                    end else if (w_waitZero) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                    end
                end
                SCAN: begin
                    if (w_compare) begin
                        r_errCount <= w_errNext;
                        if (w_mismatch && (r_errCount == '0)) begin
                            r_firstErrReg   <= r_idx;
                            r_firstErrValue <= out_value;
                        end
                        if (r_idx == c_LAST_IDX) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_errNext == '0);
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign inr             = r_idx;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign timeout         = r_timeout;
    assign err_count       = r_errCount;
    assign first_err_reg   = r_firstErrReg;
    assign first_err_value = r_firstErrValue;

endmodule
`default_nettype wire

// File: tb/tb_reg_scan_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_scan_checker
// Description : Self-checking bench for reg_scan_checker; two instances
//               (SettleCycles=1/HaltTimeout=16 and SettleCycles=0/defaults).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_scan_checker;

    logic        clk;
    logic        rstN;
    logic        start;
    logic        halted;
    logic [15:0] mask;
    logic [15:0] regs [8];
    logic [15:0] expv [8];

    logic [2:0]  inrA, inrB;
    logic [15:0] outA, outB, expA, expB;
    logic        busyA, busyB, doneA, doneB, passA, passB, toA, toB;
    logic [3:0]  errA, errB;
    logic [2:0]  ferA, ferB;
    logic [15:0] fevA, fevB;

    int checks = 0;
    int errors = 0;

    // The processor's register file and the environment's expected table
    assign outA = regs[inrA];
    assign expA = expv[inrA];
    assign outB = regs[inrB];
    assign expB = expv[inrB];

    reg_scan_checker #(
        .SettleCycles (1),
        .HaltTimeout  (16)
    ) u_dutA (
        .CLK (clk), .RST_N (rstN), .start (start), .halted (halted),
        .inr (inrA), .out_value (outA), .exp_data (expA), .exp_mask (mask),
        .busy (busyA), .done (doneA), .pass (passA), .timeout (toA),
        .err_count (errA), .first_err_reg (ferA), .first_err_value (fevA)
    );

    reg_scan_checker #(
        .SettleCycles (0)
    ) u_dutB (
        .CLK (clk), .RST_N (rstN), .start (start), .halted (halted),
        .inr (inrB), .out_value (outB), .exp_data (expB), .exp_mask (mask),
        .busy (busyB), .done (doneB), .pass (passB), .timeout (toB),
        .err_count (errB), .first_err_reg (ferB), .first_err_value (fevB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: count masked mismatches over the register file
    task automatic model(output int nErr, output int firstReg, output logic [15:0] firstVal);
        nErr = 0;
        firstReg = 0;
        firstVal = 16'h0;
        for (int i = 0; i < 8; i++) begin
            if (((regs[i] ^ expv[i]) & mask) != 16'h0) begin
                if (nErr == 0) begin
                    firstReg = i;
                    firstVal = regs[i];
                end
                nErr++;
            end
        end
        if (nErr > 15) nErr = 15;
    endtask

    function automatic int expInr(input int c, input int settle, input bit isTimeout);
        if (isTimeout || c < 2) return 0;
        return (c - 2) / (settle + 1);
    endfunction

    task automatic runScan(input string name, input bit isTimeout, input int pulseCycle);
        int nErr, firstReg;
        logic [15:0] firstVal;
        int dA, dB, expDA, expDB;
        bit badA, badB;
        model(nErr, firstReg, firstVal);
        expDA = isTimeout ? 17 : 2 + 8 * 2;
        expDB = isTimeout ? 257 : 2 + 8 * 1;
        dA = -1;
        dB = -1;
        badA = 1'b0;
        badB = 1'b0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            start = (c == pulseCycle);
            if (doneA && dA < 0) dA = c;
            if (doneB && dB < 0) dB = c;
            if (c < expDA && (busyA !== 1'b1 || doneA !== 1'b0 || int'(inrA) != expInr(c, 1, isTimeout))) badA = 1'b1;
            if (c < expDB && (busyB !== 1'b1 || doneB !== 1'b0 || int'(inrB) != expInr(c, 0, isTimeout))) badB = 1'b1;
            if (dA >= 0 && dB >= 0) break;
        end
        start = 1'b0;
        check({name, " A done cycle"}, dA, expDA);
        check({name, " B done cycle"}, dB, expDB);
        check({name, " A busy/inr sweep"}, badA, 0);
        check({name, " B busy/inr sweep"}, badB, 0);
        check({name, " A busy after done"}, busyA, 0);
        check({name, " A timeout"}, toA, isTimeout);
        check({name, " B timeout"}, toB, isTimeout);
        check({name, " A pass"}, passA, !isTimeout && nErr == 0);
        check({name, " B pass"}, passB, !isTimeout && nErr == 0);
        check({name, " A err_count"}, errA, isTimeout ? 0 : nErr);
        check({name, " B err_count"}, errB, isTimeout ? 0 : nErr);
        check({name, " A first_err_reg"}, ferA, isTimeout ? 0 : firstReg);
        check({name, " B first_err_reg"}, ferB, isTimeout ? 0 : firstReg);
        check({name, " A first_err_value"}, fevA, isTimeout ? 0 : firstVal);
        check({name, " B first_err_value"}, fevB, isTimeout ? 0 : firstVal);
    endtask

    task automatic checkAllZero(input string name);
        check({name, " A outputs"}, {inrA, busyA, doneA, passA, toA, errA, ferA, fevA}, 0);
        check({name, " B outputs"}, {inrB, busyB, doneB, passB, toB, errB, ferB, fevB}, 0);
    endtask

    task automatic setFile(input logic [15:0] value);
        for (int i = 0; i < 8; i++) begin
            regs[i] = value;
            expv[i] = value;
        end
    endtask

    initial begin
        int guard;
        bit sawDone;
        rstN   = 1'b0;
        start  = 1'b0;
        halted = 1'b1;
        mask   = 16'hFFFF;
        setFile(16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rstN = 1'b1;

        // Matching file, R1 = 1
        regs[1] = 16'h0001;
        expv[1] = 16'h0001;
        runScan("match", 1'b0, 0);

        // Single mismatch at R3
        setFile(16'h0);
        regs[3] = 16'h00FF;
        runScan("r3", 1'b0, 0);

        // Bit 15 difference masked off
        setFile(16'h0);
        regs[5] = 16'h8000;
        mask = 16'h7FFF;
        runScan("masked", 1'b0, 0);

        // Two mismatches; first reported is R2
        mask = 16'hFFFF;
        setFile(16'h1234);
        regs[2] = 16'h1235;
        regs[6] = 16'h0000;
        runScan("two", 1'b0, 0);

        // Zero mask passes anything
        for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
        mask = 16'h0000;
        runScan("nomask", 1'b0, 0);

        // Randomised files, masks and mismatch patterns
        for (int t = 0; t < 6; t++) begin
            mask = 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                expv[i] = 16'($urandom);
                regs[i] = ($urandom_range(0, 2) == 0) ? 16'($urandom) : expv[i];
            end
            runScan("rand", 1'b0, 0);
        end

        // Start pulse mid-scan is ignored
        mask = 16'hFFFF;
        setFile(16'h0);
        regs[4] = 16'h0F0F;
        runScan("midstart", 1'b0, 5);

        // Halt never arrives
        halted = 1'b0;
        runScan("timeout", 1'b1, 0);
        halted = 1'b1;

        // Reset mid-scan when A is reading R4
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        sawDone = 1'b0;
        while (inrA != 3'd4 && guard < 50) begin
            @(negedge clk);
            if (doneA) sawDone = 1'b1;
            guard++;
        end
        check("reset wait for inr=4", guard < 50, 1);
        check("reset no early done A", sawDone, 0);
        rstN = 1'b0;
        @(negedge clk);
        checkAllZero("midreset");
        rstN = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("reset no done pulse A", doneA, 0);
        end

        // Full scan after the abort
        setFile(16'h0);
        regs[7] = 16'hFFFF;
        runScan("postreset", 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_scan_checker.md
# reg_scan_checker

Synthesizable, parametrised register-file scan-and-check engine for the pipelined processor. After the processor signals halt, it steps the processor's `inr` debug read port over every architectural register and waits a programmable settle time per register. It compares `out_value` against an externally supplied expected value under a bit mask and reports pass/fail, error count and the first failing register. It sits beside `Pipelined_Processor` in on-chip/FPGA self-test and replaces hand-stepped register dumps in benches.

## Interface
- `RegAddrBits`, 3, width of `inr`
- `DataWidth`, 16, register data width
- `TotalReg`, 8, registers scanned (indices 0..TotalReg-1); 1 ≤ TotalReg ≤ 2^RegAddrBits
- `SettleCycles`, 1, cycles `inr` is held before sampling `out_value`; ≥ 0
- `HaltTimeout`, 256, max cycles in WAIT_HALT before timeout; ≥ 1
- `CLK` in 1, the single clock, rising edge
- `RST_N` in 1, reset, synchronous, active-low
- `start` in 1, request scan, sampled in IDLE or DONE only
- `halted` in 1, processor halt indication
- `inr` out RegAddrBits, register index to processor
- `out_value` in DataWidth, register contents from processor
- `exp_data` in DataWidth, expected value for current `inr` (combinational lookup by environment)
- `exp_mask` in DataWidth, 1 = bit compared
- `busy` out 1, high in WAIT_HALT and SCAN
- `done` out 1, high while in DONE
- `pass` out 1, valid when `done`
- `timeout` out 1, halt never seen
- `err_count` out RegAddrBits+1, saturating mismatch count
- `first_err_reg` out RegAddrBits, index of first mismatch
- `first_err_value` out DataWidth, `out_value` at first mismatch

## Operation
- States: IDLE, WAIT_HALT, SCAN, DONE.
- IDLE: `start`=1 → WAIT_HALT. Clear `err_count`, `first_err_*`, `timeout`, `pass`, `wait_cnt`.
- WAIT_HALT: `halted`=1 → SCAN with `idx`=0, `settle_cnt`=0. Otherwise `wait_cnt`++. When `wait_cnt`==HaltTimeout-1 and still not halted → DONE with `timeout`=1.
- SCAN: `inr`=`idx`.
  - If `settle_cnt`<SettleCycles: `settle_cnt`++.
  - Otherwise this is the compare cycle. Mismatch when ((`out_value` ^ `exp_data`) & `exp_mask`) ≠ 0.
  - On mismatch: `err_count`++ (saturates at all-ones). If this is the first mismatch, latch `idx` and `out_value` into `first_err_*`.
  - After the compare: if `idx`==TotalReg-1 → DONE. Else `idx`++, `settle_cnt`=0.
- DONE: `done`=1. `pass` = (`err_count`==0 && !`timeout`), registered on entry. `start`=1 restarts exactly as from IDLE.
- `start` is ignored while `busy`.
- `halted` falling during SCAN is ignored.
- `exp_mask`=0 makes every register pass.

## Timing
- Reset (`RST_N`=0 at a rising edge): state IDLE, and every output is 0 (`inr`, `busy`, `done`, `pass`, `timeout`, `err_count`, `first_err_reg`, `first_err_value`). Reset mid-scan aborts with no `done` pulse.
- All outputs are registered; there are no combinational input→output paths.
- Cycle 0 is the cycle `start` is sampled. Cycle 1: WAIT_HALT, `busy`=1.
- With `halted` already high: SCAN begins at cycle 2. Each register occupies SettleCycles+1 cycles. `done` rises in cycle 2+TotalReg·(SettleCycles+1); with defaults this is cycle 18.
- `out_value` and `exp_data` are sampled on the compare-cycle edge, SettleCycles cycles after `inr` changes.
- Timeout: `done`=1, `timeout`=1 in cycle 1+HaltTimeout. `inr` stays 0.

## Structure
- Shared package `pp_selftest_pkg` holds:
  - the `scan_state_t` enum (IDLE, WAIT_HALT, SCAN, DONE);
  - the masked-compare function;
  - the default parameter constants, shared with `Pipelined_Processor`: RegAddrBits=3, DataWidth=16.
- One natural sub-module: `settle_counter`. It is a loadable down-counter producing the compare-cycle strobe and is reused for `wait_cnt`.
- Everything else stays inline; target 150–250 lines.

## Test plan
- Defaults, `halted`=1. `out_value`=`exp_data` for all regs (R1=0x0001, others 0x0000), mask 0xFFFF → `done` at cycle 18, `pass`=1, `err_count`=0, `inr` swept 0..7.
- R3 returns 0x00FF, expected 0x0000, mask 0xFFFF → `err_count`=1, `first_err_reg`=3, `first_err_value`=0x00FF, `pass`=0.
- R5 differs only in bit 15, mask 0x7FFF → `pass`=1. R2 and R6 both mismatch → `err_count`=2, `first_err_reg`=2.
- HaltTimeout=16, `halted` held 0 → `done` and `timeout` at cycle 17, `pass`=0, `inr`=0 throughout.
- `RST_N`=0 for one edge while `inr`=4 → all outputs 0 on the next cycle. A later `start` runs a full scan to `done`. `start` pulsed during SCAN has no effect.
- SettleCycles=0, TotalReg=8 → `done` at cycle 10. A `start` in DONE clears the previous `err_count` and reruns.
